// File: rtl/a2d_spi_resp.sv
// SPI responder that stands in for the 8-channel 12-bit A2D converter.
// Each frame returns the result for the channel addressed in the previous frame.
`timescale 1ns/1ps
module a2d_spi_resp #(
    parameter int NUM_CH  = 8,
    parameter int RES_W   = 12,
    parameter int FRAME_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    SS_n,
    input  logic                    SCLK,
    input  logic                    MOSI,
    input  logic [NUM_CH*RES_W-1:0] ch_data,
    output logic                    MISO,
    output logic [2:0]              chnnl_o,
    output logic                    frm_done,
    output logic                    frm_err
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             r_state;
    logic               r_ssMeta, r_ssSync, r_ssDly;
    logic               r_sclkMeta, r_sclkSync, r_sclkDly;
    logic               r_mosiMeta, r_mosiSync, r_mosiDly;
    logic [FRAME_W-1:0] r_rxShft;
    logic [FRAME_W-1:0] r_txShft;
    logic [4:0]         r_bitCnt;
    logic [RES_W-1:0]   w_selData;
    logic               w_ssFall, w_ssRise, w_sclkRise, w_sclkFall;

    // SS_n flops reset low so a reset released mid-frame never looks like a fresh SS_n fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ssMeta   <= 1'b0;
            r_ssSync   <= 1'b0;
            r_ssDly    <= 1'b0;
            r_sclkMeta <= 1'b0;
            r_sclkSync <= 1'b0;
            r_sclkDly  <= 1'b0;
            r_mosiMeta <= 1'b0;
            r_mosiSync <= 1'b0;
            r_mosiDly  <= 1'b0;
        end else begin
            r_ssMeta   <= SS_n;
            r_ssSync   <= r_ssMeta;
            r_ssDly    <= r_ssSync;
            r_sclkMeta <= SCLK;
            r_sclkSync <= r_sclkMeta;
            r_sclkDly  <= r_sclkSync;
            r_mosiMeta <= MOSI;
            r_mosiSync <= r_mosiMeta;
            r_mosiDly  <= r_mosiSync;
        end
    end

    assign w_ssFall   =  r_ssDly   & ~r_ssSync;
    assign w_ssRise   = ~r_ssDly   &  r_ssSync;
    assign w_sclkRise = ~r_sclkDly &  r_sclkSync;
    assign w_sclkFall =  r_sclkDly & ~r_sclkSync;

    always_comb begin
        w_selData = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (32'(chnnl_o) == k) begin
                w_selData = ch_data[k*RES_W +: RES_W];
            end
        end
    end

    // The transmit shifter doubles as the sample-and-hold: it is loaded once per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rxShft <= '0;
            r_txShft <= '0;
            r_bitCnt <= '0;
            chnnl_o  <= '0;
            frm_done <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            frm_done <= 1'b0;
            frm_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ssFall) begin
                        r_txShft <= {{(FRAME_W-RES_W){1'b0}}, w_selData};
                        r_bitCnt <= '0;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_ssRise) begin
                        if (r_bitCnt == 5'(FRAME_W)) begin
                            chnnl_o  <= r_rxShft[13:11];
                            frm_done <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
                        r_state <= IDLE;
                    end else if (w_sclkRise) begin
                        r_rxShft <= {r_rxShft[FRAME_W-2:0], r_mosiDly};
                        if (r_bitCnt != 5'd31) begin
                            r_bitCnt <= r_bitCnt + 5'd1;
                        end
                    end else if (w_sclkFall && r_bitCnt != 5'd0) begin
                        r_txShft <= {r_txShft[FRAME_W-2:0], 1'b0};
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign MISO = (r_state == SHIFT) & r_txShft[FRAME_W-1];

endmodule
